// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count scheduler: FSM state encoding,
// the decade counter's terminal value and the default data width.
package count_sched_pkg;

  localparam int MAX_COUNT = 9;
  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// Round-robin arbiter: scans requesters starting just after the last one
// served, so the last-served requester always has the lowest priority.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  // Pick the first active requester after the pointer, wrapping around
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Count scheduler: shares one external decade counter between NREQ
// requesters. Each granted requester gets the counter loaded with zero and
// then enabled for its (clamped) tick count, followed by a Done pulse.
// Optional build macro: COUNT_SCHED_ASSERT_EN adds protocol assertions.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = DEFAULT_W
) (
  input  logic                    CLK,
  input  logic                    MR,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ-1:0][W-1:0]  Len,
  output logic [NREQ-1:0]         Grant,
  output logic [NREQ-1:0]         Done,
  output logic                    Busy,
  output logic [W-1:0]            P,
  output logic                    Load,
  output logic                    Enable,
  output logic                    CMR,
  input  logic [W-1:0]            Q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state;
  logic [PW-1:0]  last;
  logic [PW-1:0]  owner;
  logic [W-1:0]   len_lat;

  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic [W-1:0]    win_len;
  logic [W-1:0]    win_len_clamped;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (Req),
    .ptr   (last),
    .grant (win)
  );

  // Encode the one-hot winner and clamp its requested length to the decade range
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) win_idx = PW'(k);
    end
    win_len         = Len[win_idx];
    win_len_clamped = (win_len > W'(MAX_COUNT)) ? W'(MAX_COUNT) : win_len;
  end

  // Scheduler FSM with every output registered alongside the state
  always_ff @(posedge CLK) begin
    if (MR) begin
      state   <= IDLE;
      Grant   <= '0;
      Done    <= '0;
      Busy    <= 1'b0;
      P       <= '0;
      Load    <= 1'b0;
      Enable  <= 1'b0;
      CMR     <= 1'b1;
      last    <= PW'(NREQ - 1);
      owner   <= '0;
      len_lat <= '0;
    end else begin
      CMR  <= 1'b0;
      Done <= '0;
      Load <= 1'b0;
      P    <= '0;
      case (state)
        IDLE: begin
          if (|Req) begin
            Grant   <= win;
            owner   <= win_idx;
            last    <= win_idx;
            len_lat <= win_len_clamped;
            Busy    <= 1'b1;
            if (win_len == '0) begin
              state  <= DONE;
              Done   <= win;
              Enable <= 1'b0;
            end else begin
              state <= LOAD;
              Load  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!Req[owner]) begin
            state  <= IDLE;
            Grant  <= '0;
            Enable <= 1'b0;
            Busy   <= 1'b0;
          end else begin
            state  <= RUN;
            Enable <= 1'b1;
          end
        end
        RUN: begin
          if (!Req[owner]) begin
            state  <= IDLE;
            Grant  <= '0;
            Enable <= 1'b0;
            Busy   <= 1'b0;
          end else if (Q == len_lat - W'(1)) begin
            state  <= DONE;
            Enable <= 1'b0;
            Done   <= Grant;
          end
        end
        DONE: begin
          state  <= IDLE;
          Grant  <= '0;
          Enable <= 1'b0;
          Busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Grant <= '0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNT_SCHED_ASSERT_EN
  // Flag counter overrun and output protocol violations while out of reset
  always_ff @(posedge CLK) begin
    if (!MR) begin
      if (state == RUN) begin
        assert (Q <= W'(MAX_COUNT)) else $error("count_sched: Q out of decade range");
      end
      assert ($onehot0(Grant)) else $error("count_sched: Grant not one-hot0");
      assert (!(Load && Enable)) else $error("count_sched: Load and Enable together");
      assert ((Done & ~Grant) == '0) else $error("count_sched: Done without Grant");
    end
  end
`endif

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched with a behavioural decade counter closing
// the loop on P/Load/Enable/CMR -> Q.
module tb_count_sched;
  import count_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = DEFAULT_W;

  logic                   clk;
  logic                   mr;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][W-1:0] len;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic                   busy;
  logic [W-1:0]           p;
  logic                   load;
  logic                   enable;
  logic                   cmr;
  logic [W-1:0]           q;

  int check_count = 0;
  int error_count = 0;

  count_sched #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .CLK    (clk),
    .MR     (mr),
    .Req    (req),
    .Len    (len),
    .Grant  (grant),
    .Done   (done),
    .Busy   (busy),
    .P      (p),
    .Load   (load),
    .Enable (enable),
    .CMR    (cmr),
    .Q      (q)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External decade counter driven by the scheduler
  always @(posedge clk) begin
    if (cmr) q <= '0;
    else if (load) q <= p;
    else if (enable) q <= (q == W'(9)) ? '0 : q + W'(1);
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input int len0, input int len1);
    req    = r;
    len[0] = W'(len0);
    len[1] = W'(len1);
  endtask

  task automatic applyReset();
    mr  = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLoad", load, 0);
    checkOutput("rstEnable", enable, 0);
    checkOutput("rstP", p, 0);
    checkOutput("rstCmr", cmr, 1);
    mr = 1'b0;
    @(negedge clk);
    checkOutput("cmrRelease", cmr, 0);
  endtask

  // Follow one complete grant of requester idx with expL enable cycles
  task automatic serve(input int idx, input int expL, input bit drop_all);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    @(negedge clk);
    checkOutput("grant", grant, oh);
    checkOutput("busy", busy, 1);
    if (expL == 0) begin
      checkOutput("doneZero", done, oh);
      checkOutput("enZero", enable, 0);
      checkOutput("loadZero", load, 0);
    end else begin
      checkOutput("load", load, 1);
      checkOutput("loadEn", enable, 0);
      for (int k = 0; k < expL; k++) begin
        @(negedge clk);
        checkOutput("enable", enable, 1);
        checkOutput("loadLow", load, 0);
        checkOutput("qRun", q, k);
        checkOutput("noDone", done, 0);
      end
      @(negedge clk);
      checkOutput("done", done, oh);
      checkOutput("enOff", enable, 0);
      checkOutput("qDone", q, expL);
    end
    if (drop_all) req = '0;
    @(negedge clk);
    checkOutput("idleGrant", grant, 0);
    checkOutput("idleDone", done, 0);
    checkOutput("idleBusy", busy, 0);
  endtask

  initial begin
    mr  = 1'b1;
    req = '0;
    len = '0;
    applyReset();

    $display("[TB] single request, length 3");
    applyStimulus(2'b01, 3, 0);
    serve(0, 3, 1'b1);

    $display("[TB] alternating requesters");
    applyReset();
    applyStimulus(2'b11, 2, 4);
    serve(0, 2, 1'b0);
    serve(1, 4, 1'b0);
    serve(0, 2, 1'b1);

    $display("[TB] zero length");
    applyStimulus(2'b01, 0, 0);
    serve(0, 0, 1'b1);

    $display("[TB] clamped length");
    applyStimulus(2'b10, 0, 12);
    serve(1, 9, 1'b1);

    $display("[TB] owner abort in RUN");
    applyStimulus(2'b11, 5, 2);
    @(negedge clk);
    checkOutput("abGrant", grant, 2'b01);
    repeat (3) @(negedge clk);
    checkOutput("abQ", q, 2);
    checkOutput("abEnable", enable, 1);
    req[0] = 1'b0;
    @(negedge clk);
    checkOutput("abEnOff", enable, 0);
    checkOutput("abGrantOff", grant, 0);
    checkOutput("abNoDone", done, 0);
    checkOutput("abBusy", busy, 0);
    @(negedge clk);
    checkOutput("abNext", grant, 2'b10);
    checkOutput("abNextLoad", load, 1);
    req = '0;
    @(negedge clk);
    checkOutput("ldAbGrant", grant, 0);
    checkOutput("ldAbDone", done, 0);
    checkOutput("ldAbEnable", enable, 0);

    $display("[TB] reset pulse in RUN");
    applyStimulus(2'b01, 5, 0);
    @(negedge clk);
    checkOutput("mrGrant", grant, 2'b01);
    repeat (2) @(negedge clk);
    checkOutput("mrRun", enable, 1);
    mr = 1'b1;
    @(negedge clk);
    checkOutput("mrGrantOff", grant, 0);
    checkOutput("mrEnable", enable, 0);
    checkOutput("mrLoad", load, 0);
    checkOutput("mrBusy", busy, 0);
    checkOutput("mrDone", done, 0);
    checkOutput("mrCmr", cmr, 1);
    mr  = 1'b0;
    req = '0;
    @(negedge clk);
    checkOutput("mrCmrOff", cmr, 0);
    checkOutput("mrNoDone", done, 0);
    checkOutput("mrQ", q, 0);
    applyStimulus(2'b11, 1, 1);
    serve(0, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
